// File: rtl/img_pkg.sv
// Image geometry and frame FSM encoding shared by the pixel packer and Main_Ctrl_Unit.
package img_pkg;
  localparam int IMG_DIM    = 20;
  localparam int BIT_LENGTH = 5;
  localparam int TOTAL_PIX  = IMG_DIM * IMG_DIM;
  localparam int PIX_CNT_W  = 9;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] TAIL   = 2'd2;
endpackage

// File: rtl/pix_fifo.sv
// Pixel buffer kept as a packed shift vector: entry 0 is always the oldest pixel,
// so the three head entries come straight off flops. One push, pop of 0..3, flush.
module pix_fifo #(
  parameter int DEPTH = 6,
  parameter int W     = 5,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic [1:0]       pop_cnt,
  input  logic             flush,
  output logic [W-1:0]     head0,
  output logic [W-1:0]     head1,
  output logic [W-1:0]     head2,
  output logic [OCC_W-1:0] occ
);
  localparam int VW = DEPTH * W;

  logic [VW-1:0]    mem_q, shifted, mem_n;
  logic [OCC_W-1:0] occ_q, base, occ_n;

  always_comb begin
    shifted = mem_q >> (int'(pop_cnt) * W);
    base    = flush ? '0 : occ_q - OCC_W'(pop_cnt);
    occ_n   = base + OCC_W'(push);
    mem_n   = shifted;
    if (push) begin
      mem_n = (shifted & ~({{(VW-W){1'b0}}, {W{1'b1}}} << (int'(base) * W)))
            | ({{(VW-W){1'b0}}, push_data} << (int'(base) * W));
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_n;
    if (reset) occ_q <= '0;
    else       occ_q <= occ_n;
  end

  assign head0 = mem_q[W-1:0];
  assign head1 = mem_q[2*W-1:W];
  assign head2 = mem_q[3*W-1:2*W];
  assign occ   = occ_q;
endmodule

// File: rtl/pixel_stream_packer.sv
// Packs a 1-pixel/cycle stream into 3-pixel beats with load_end on the last beat of a frame.
// Optional PIX_CKSUM_EN adds a per-frame mod-256 pixel checksum (cksum, cksum_valid).
module pixel_stream_packer
  import img_pkg::*;
#(
  parameter int IMG_DIM    = img_pkg::IMG_DIM,
  parameter int BIT_LENGTH = img_pkg::BIT_LENGTH,
  parameter int FIFO_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIT_LENGTH-1:0] in_pixel,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [BIT_LENGTH-1:0] out_pixel0,
  output logic [BIT_LENGTH-1:0] out_pixel1,
  output logic [BIT_LENGTH-1:0] out_pixel2,
  output logic [1:0]            out_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  load_end,
`ifdef PIX_CKSUM_EN
  output logic [7:0]            cksum,
  output logic                  cksum_valid,
`endif
  output logic                  frame_err
);
  localparam int TOTAL = IMG_DIM * IMG_DIM;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  function automatic logic [1:0] sat_lanes(input logic [OCC_W-1:0] occ_v);
    return (occ_v >= OCC_W'(3)) ? 2'd3 : occ_v[1:0];
  endfunction

  logic                  push, pop, flush, store, err_set;
  logic [1:0]            pop_cnt;
  state_t                state_q, state_n;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_n;
  logic [OCC_W-1:0]      occ, occ_n;
  logic [BIT_LENGTH-1:0] head0, head1, head2;
  logic                  vld_p1, last_p1, rdy_p1, frame_err_q;
  logic [1:0]            cnt_p1;
  logic                  vld_n, last_n, rdy_n;
  logic [1:0]            cnt_n;

  assign push    = in_valid && rdy_p1;
  assign pop     = vld_p1 && out_ready;
  assign pop_cnt = pop ? cnt_p1 : 2'd0;
  assign flush   = push && in_sof && (state_q == STREAM);
  assign store   = push && ((state_q == STREAM) || ((state_q == IDLE) && in_sof));

  pix_fifo #(.DEPTH(FIFO_DEPTH), .W(BIT_LENGTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (store),
    .push_data (in_pixel),
    .pop_cnt   (pop_cnt),
    .flush     (flush),
    .head0     (head0),
    .head1     (head1),
    .head2     (head2),
    .occ       (occ)
  );

  always_comb begin
    state_n   = state_q;
    pix_cnt_n = pix_cnt_q;
    err_set   = 1'b0;
    occ_n     = flush ? OCC_W'(store) : occ - OCC_W'(pop_cnt) + OCC_W'(store);
    case (state_q)
      IDLE: begin
        if (push) begin
          if (in_sof) begin
            state_n   = STREAM;
            pix_cnt_n = CNT_W'(1);
          end else begin
            err_set = 1'b1;
          end
        end
      end
      STREAM: begin
        if (push) begin
          if (in_sof) begin
            pix_cnt_n = CNT_W'(1);
            err_set   = 1'b1;
          end else begin
            pix_cnt_n = pix_cnt_q + CNT_W'(1);
            if (pix_cnt_n == CNT_W'(TOTAL)) state_n = TAIL;
          end
        end
      end
      TAIL: begin
        if (pop && last_p1) begin
          state_n   = IDLE;
          pix_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    vld_n  = (occ_n >= OCC_W'(3)) || ((state_n == TAIL) && (occ_n != '0));
    cnt_n  = vld_n ? sat_lanes(occ_n) : 2'd0;
    last_n = vld_n && (state_n == TAIL) && (occ_n <= OCC_W'(3));
    rdy_n  = (occ_n < OCC_W'(FIFO_DEPTH)) && (state_n != TAIL);
  end

  // Stage p1: beat control registered from next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      vld_p1      <= 1'b0;
      cnt_p1      <= 2'd0;
      last_p1     <= 1'b0;
      rdy_p1      <= 1'b0;
    end else begin
      state_q     <= state_n;
      pix_cnt_q   <= pix_cnt_n;
      frame_err_q <= frame_err_q | err_set;
      vld_p1      <= vld_n;
      cnt_p1      <= cnt_n;
      last_p1     <= last_n;
      rdy_p1      <= rdy_n;
    end
  end

  assign in_ready   = rdy_p1;
  assign out_valid  = vld_p1;
  assign out_count  = cnt_p1;
  assign load_end   = last_p1;
  assign frame_err  = frame_err_q;
  assign out_pixel0 = (cnt_p1 >= 2'd1) ? head0 : '0;
  assign out_pixel1 = (cnt_p1 >= 2'd2) ? head1 : '0;
  assign out_pixel2 = (cnt_p1 == 2'd3) ? head2 : '0;

`ifdef PIX_CKSUM_EN
  logic [7:0] acc_q, cksum_p1;
  logic       cksum_vld_p1;

  always_ff @(posedge clk) begin
    if (store) begin
      if ((state_q == IDLE) || flush) acc_q <= 8'(in_pixel);
      else                            acc_q <= acc_q + 8'(in_pixel);
    end
  end

  // Stage p1: checksum published the cycle after the load_end handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      cksum_vld_p1 <= 1'b0;
      cksum_p1     <= 8'd0;
    end else begin
      cksum_vld_p1 <= pop && last_p1;
      if (pop && last_p1) cksum_p1 <= acc_q;
    end
  end

  assign cksum       = cksum_p1;
  assign cksum_valid = cksum_vld_p1;
`endif
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: frame-level beat model plus directed frame scenarios.
module tb_pixel_stream_packer;
  localparam int TOTAL = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] in_pixel = '0;
  logic       in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, load_end, frame_err;
  logic [4:0] out_pixel0, out_pixel1, out_pixel2;
  logic [1:0] out_count;
`ifdef PIX_CKSUM_EN
  logic [7:0] cksum;
  logic       cksum_valid;
`endif

  pixel_stream_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .out_pixel0 (out_pixel0),
    .out_pixel1 (out_pixel1),
    .out_pixel2 (out_pixel2),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .load_end   (load_end),
`ifdef PIX_CKSUM_EN
    .cksum      (cksum),
    .cksum_valid(cksum_valid),
`endif
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] cnt;
    logic [4:0] p0, p1, p2;
    logic       last;
  } beat_t;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bt(input int n, input int a, input int b, input int c, input int l);
    return 32'({2'(n), 5'(a), 5'(b), 5'(c), 1'(l)});
  endfunction

  // Frame-level model: accepted pixels are grouped in threes into expected beats.
  beat_t      exp_q[$];
  logic [4:0] part[$];
  beat_t      obs[$];
  int         m_cnt = 0, m_sum = 0, frames_done = 0;
  bit         m_in_frame = 0, m_tail = 0, m_err = 0, prev_rst = 0;
  bit         ev, ev_last, exp_rdy, cks_due = 0, cks_next = 0;
  logic [7:0] cks_val = '0, last_cks = '0;

  task automatic emit(input bit last);
    beat_t b;
    b.cnt  = 2'(part.size());
    b.p0   = part[0];
    b.p1   = (part.size() > 1) ? part[1] : 5'd0;
    b.p2   = (part.size() > 2) ? part[2] : 5'd0;
    b.last = last;
    exp_q.push_back(b);
    part.delete();
  endtask

  task automatic model_push(input logic [4:0] px, input logic sof);
    if (sof) begin
      if (m_in_frame) begin
        m_err = 1;
        exp_q.delete();
      end
      part.delete();
      part.push_back(px);
      m_in_frame = 1;
      m_cnt = 1;
      m_sum = int'(px);
    end else if (!m_in_frame) begin
      m_err = 1;
    end else begin
      part.push_back(px);
      m_cnt++;
      m_sum += int'(px);
      if (part.size() == 3) emit(m_cnt == TOTAL);
      if (m_cnt == TOTAL) begin
        if (part.size() > 0) emit(1);
        m_tail = 1;
        m_in_frame = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); part.delete(); obs.delete();
      m_cnt = 0; m_sum = 0; frames_done = 0;
      m_in_frame = 0; m_tail = 0; m_err = 0; cks_due = 0; prev_rst = 1;
    end else if (prev_rst) begin
      prev_rst = 0;
      check("reset_outputs", 32'({out_valid, in_ready, frame_err, load_end, out_count,
                                  out_pixel0, out_pixel1, out_pixel2}), 32'd0);
`ifdef PIX_CKSUM_EN
      check("reset_cksum", 32'({cksum_valid, cksum}), 32'd0);
`endif
    end else begin
      ev      = exp_q.size() > 0;
      ev_last = ev ? exp_q[0].last : 1'b0;
      exp_rdy = !m_tail && ((3 * exp_q.size() + part.size()) < 6);
      check("ctrl{valid,ready,err,load_end}", 32'({out_valid, in_ready, frame_err, load_end}),
            32'({ev, exp_rdy, m_err, ev_last}));
      if (out_valid && ev)
        check("beat{count,p0,p1,p2}", 32'({out_count, out_pixel0, out_pixel1, out_pixel2}),
              32'({exp_q[0].cnt, exp_q[0].p0, exp_q[0].p1, exp_q[0].p2}));
`ifdef PIX_CKSUM_EN
      check("cksum_valid", 32'(cksum_valid), 32'(cks_due));
      if (cks_due) check("cksum", 32'(cksum), 32'(cks_val));
      if (cksum_valid) last_cks = cksum;
`endif
      cks_next = 0;
      if (out_valid && out_ready) begin
        obs.push_back(beat_t'({out_count, out_pixel0, out_pixel1, out_pixel2, load_end}));
        if (ev) begin
          if (exp_q[0].last) begin
            m_tail = 0;
            frames_done++;
            cks_next = 1;
            cks_val = 8'(m_sum);
          end
          void'(exp_q.pop_front());
        end
      end
      cks_due = cks_next;
      if (in_valid && in_ready) model_push(in_pixel, in_sof);
    end
  end

  task automatic send_px(input logic [4:0] px, input logic sof);
    int guard = 0;
    in_pixel = px; in_sof = sof; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 500) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_px(5'(i % 32), i == 0);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_frame_end(input int target);
    int g = 0;
    while (frames_done < target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (frames_done < target) check("frame_end_timeout", 32'(frames_done), 32'(target));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_tail(input string tag);
    int nl = 0;
    foreach (obs[k]) if (obs[k].last) nl++;
    check({tag, "_load_end_count"}, 32'(nl), 32'd1);
    check({tag, "_last_beat"}, 32'(obs[obs.size() - 1]), bt(1, 15, 0, 0, 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Test 1: clean frame, consumer always ready
    send_frame(TOTAL, 0);
    wait_frame_end(1);
    check("t1_beats", 32'(obs.size()), 32'd134);
    check("t1_beat0", 32'(obs[0]), bt(3, 0, 1, 2, 0));
    check("t1_beat10", 32'(obs[10]), bt(3, 30, 31, 0, 0));
    check_tail("t1");
`ifdef PIX_CKSUM_EN
    check("t6_cksum", 32'(last_cks), 32'h0B8);
`endif

    // Test 2: consumer stalls for 10 cycles after the third beat
    do_reset();
    fork
      send_frame(TOTAL, 0);
      begin
        int g = 0;
        while (obs.size() < 3 && g < 500) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("t2_backpressure{valid,ready}", 32'({out_valid, in_ready}), 32'b10);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_frame_end(1);
    check("t2_beats", 32'(obs.size()), 32'd134);
    check("t2_beat3", 32'(obs[3]), bt(3, 9, 10, 11, 0));
    check_tail("t2");

    // Test 3: in_valid every other cycle
    do_reset();
    send_frame(TOTAL, 1);
    wait_frame_end(1);
    check("t3_beats", 32'(obs.size()), 32'd134);
    check("t3_beat50", 32'(obs[50]), bt(3, 22, 23, 24, 0));
    check_tail("t3");

    // Test 4: new frame starts at pixel 50 of a running frame
    do_reset();
    send_frame(50, 0);
    send_frame(TOTAL, 0);
    wait_frame_end(1);
    @(negedge clk);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check_tail("t4");

    // Test 5: pixels without sof in IDLE, then reset in mid-frame
    do_reset();
    send_px(5'd7, 1'b0);
    send_px(5'd8, 1'b0);
    send_px(5'd9, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_discard{err,valid}", 32'({frame_err, out_valid}), 32'b10);
    do_reset();
    send_frame(200, 0);
    do_reset();
    send_frame(TOTAL, 0);
    wait_frame_end(1);
    @(negedge clk);
    check("t5_frame_err_clear", 32'(frame_err), 32'd0);
    check("t5_beats", 32'(obs.size()), 32'd134);
    check_tail("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
